// File: rtl/text_console_writer.sv
// Glyph/control-code stream to packed text frame buffer writer.
// Cursor tracking, byte-lane read-modify-write, and full-screen clear.
module text_console_writer #(
  parameter int                    ADDR_WIDTH    = 16,
  parameter logic [ADDR_WIDTH-1:0] FB_START      = 16'h3000,
  parameter int                    WORDS_PER_ROW = 40,
  parameter int                    ROWS          = 60,
  parameter logic [15:0]           CLEAR_WORD    = 16'h0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            char_in,
  input  logic                  char_valid,
  output logic                  char_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [15:0]           mem_rdata,
  output logic [15:0]           mem_wdata,
  output logic                  mem_we,
  output logic [6:0]            cursor_col,
  output logic [5:0]            cursor_row,
  output logic                  busy
);

  localparam logic [1:0] S_CLEAR = 2'd0;
  localparam logic [1:0] S_IDLE  = 2'd1;
  localparam logic [1:0] S_READ  = 2'd2;
  localparam logic [1:0] S_MERGE = 2'd3;

  localparam int CELLS = ROWS * WORDS_PER_ROW;
  localparam int CW    = $clog2(CELLS);

  localparam logic [CW-1:0] LAST_IDX = CW'(CELLS - 1);
  localparam logic [6:0]    LAST_COL = 7'd79;
  localparam logic [5:0]    LAST_ROW = 6'(ROWS - 1);

  localparam logic [7:0] C_BS = 8'h08;
  localparam logic [7:0] C_LF = 8'h0A;
  localparam logic [7:0] C_FF = 8'h0C;
  localparam logic [7:0] C_CR = 8'h0D;

  logic [1:0]            state;
  logic [CW-1:0]         clr_idx;
  logic [6:0]            col;
  logic [5:0]            row;
  logic [7:0]            chr;
  logic                  we_q;
  logic                  ready_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] cell_addr;
  logic [5:0]            row_inc;

  assign cell_addr = FB_START
                   + ADDR_WIDTH'(row) * ADDR_WIDTH'(WORDS_PER_ROW)
                   + ADDR_WIDTH'(col[6:1]);

  assign row_inc = (row == LAST_ROW) ? 6'd0 : row + 6'd1;

  // Gate with reset so a pending write never lands in a reset cycle.
  assign mem_we     = we_q & reset;
  assign mem_addr   = addr_q;
  assign char_ready = ready_q;
  assign cursor_col = col;
  assign cursor_row = row;
  assign busy       = (state != S_IDLE);

  // Read data arrives during MERGE, so the merge is combinational.
  always_comb begin
    mem_wdata = CLEAR_WORD;
    if (state == S_MERGE) begin
      mem_wdata = col[0] ? {mem_rdata[15:8], chr}
                         : {chr, mem_rdata[7:0]};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= S_CLEAR;
      clr_idx <= '0;
      col     <= '0;
      row     <= '0;
      chr     <= '0;
      we_q    <= 1'b0;
      ready_q <= 1'b0;
      addr_q  <= FB_START;
    end else begin
      unique case (state)
        S_CLEAR: begin
          if (!we_q) begin
            we_q <= 1'b1;
          end else if (clr_idx == LAST_IDX) begin
            we_q    <= 1'b0;
            ready_q <= 1'b1;
            col     <= '0;
            row     <= '0;
            state   <= S_IDLE;
          end else begin
            clr_idx <= clr_idx + 1'b1;
            addr_q  <= FB_START + ADDR_WIDTH'(clr_idx)
                     + ADDR_WIDTH'(1);
          end
        end
        S_IDLE: begin
          if (char_valid) begin
            if (char_in >= 8'h20) begin
              chr     <= char_in;
              addr_q  <= cell_addr;
              ready_q <= 1'b0;
              state   <= S_READ;
            end else begin
              case (char_in)
                C_LF: begin
                  col <= '0;
                  row <= row_inc;
                end
                C_CR: col <= '0;
                C_BS: begin
                  if (col != 7'd0) begin
                    col <= col - 7'd1;
                  end else if (row != 6'd0) begin
                    row <= row - 6'd1;
                    col <= LAST_COL;
                  end
                end
                C_FF: begin
                  clr_idx <= '0;
                  addr_q  <= FB_START;
                  ready_q <= 1'b0;
                  state   <= S_CLEAR;
                end
                default: ;
              endcase
            end
          end
        end
        S_READ: begin
          we_q  <= 1'b1;
          state <= S_MERGE;
        end
        S_MERGE: begin
          we_q    <= 1'b0;
          ready_q <= 1'b1;
          state   <= S_IDLE;
          if (col == LAST_COL) begin
            col <= '0;
            row <= row_inc;
          end else begin
            col <= col + 7'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_text_console_writer.sv
// Directed bench for text_console_writer.
// Vector table plus clear, wrap and reset-abort sequences.
module tb_text_console_writer;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  char_in;
  logic        char_valid;
  logic        char_ready;
  logic [15:0] mem_addr;
  logic [15:0] mem_rdata;
  logic [15:0] mem_wdata;
  logic        mem_we;
  logic [6:0]  cursor_col;
  logic [5:0]  cursor_row;
  logic        busy;

  int total = 0;
  int bad   = 0;
  int wr_cnt = 0;
  logic [15:0] last_addr = '0;
  logic [15:0] last_wd   = '0;

  typedef struct {
    logic [7:0]  ch;
    logic [15:0] rd;
    bit          we;
    logic [15:0] addr;
    logic [15:0] wd;
    int          col;
    int          row;
  } vec_t;

  vec_t tbl[22];

  text_console_writer dut (
    .clk        (clk),
    .reset      (reset),
    .char_in    (char_in),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) begin
      wr_cnt    <= wr_cnt + 1;
      last_addr <= mem_addr;
      last_wd   <= mem_wdata;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic run_clear(input string nm, input int stop_at);
    int n, errs, cyc;
    n = 0; errs = 0; cyc = 0;
    while (!char_ready && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (mem_we) begin
        if (mem_addr !== 16'(16'h3000 + n) || mem_wdata !== 16'h0)
          errs++;
        n++;
        if (stop_at != 0 && n == stop_at) break;
      end else if (n > 0 && !char_ready) begin
        errs++;
      end
    end
    chk({nm, " seq_errs"}, errs, 0);
    if (stop_at == 0) begin
      chk({nm, " writes"}, n, 2400);
      chk({nm, " ready"}, char_ready, 1);
      chk({nm, " col"}, cursor_col, 0);
      chk({nm, " row"}, cursor_row, 0);
    end else begin
      chk({nm, " stop_n"}, n, stop_at);
    end
  endtask

  task automatic send(input vec_t v, input string nm);
    int cyc, w0;
    cyc = 0;
    while (!char_ready && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk({nm, " rdy"}, char_ready, 1);
    char_in = v.ch;
    char_valid = 1'b1;
    mem_rdata = v.rd;
    w0 = wr_cnt;
    @(posedge clk);
    #1;
    char_valid = 1'b0;
    if (v.ch >= 8'h20) begin
      cyc = 0;
      while (!char_ready && cyc < 10) begin
        @(posedge clk);
        #1;
        cyc++;
      end
      chk({nm, " latency"}, cyc, 2);
    end else begin
      chk({nm, " ready_hold"}, char_ready, 1);
    end
    chk({nm, " nwr"}, wr_cnt - w0, v.we ? 1 : 0);
    if (v.we) begin
      chk({nm, " addr"}, last_addr, v.addr);
      chk({nm, " wdata"}, last_wd, v.wd);
    end
    chk({nm, " col"}, cursor_col, v.col);
    chk({nm, " row"}, cursor_row, v.row);
    @(negedge clk);
  endtask

  initial begin
    vec_t v;
    tbl[0]  = '{8'h41, 16'h1234, 1, 16'h3000, 16'h4134, 1, 0};
    tbl[1]  = '{8'h42, 16'h4134, 1, 16'h3000, 16'h4142, 2, 0};
    tbl[2]  = '{8'h0A, 16'h0, 0, 16'h0, 16'h0, 0, 1};
    tbl[3]  = '{8'h08, 16'h0, 0, 16'h0, 16'h0, 79, 0};
    tbl[4]  = '{8'h43, 16'hAAAA, 1, 16'h3027, 16'hAA43, 0, 1};
    tbl[5]  = '{8'h08, 16'h0, 0, 16'h0, 16'h0, 79, 0};
    tbl[6]  = '{8'h08, 16'h0, 0, 16'h0, 16'h0, 78, 0};
    tbl[7]  = '{8'h44, 16'h5555, 1, 16'h3027, 16'h4455, 79, 0};
    tbl[8]  = '{8'h0D, 16'h0, 0, 16'h0, 16'h0, 0, 0};
    tbl[9]  = '{8'h08, 16'h0, 0, 16'h0, 16'h0, 0, 0};
    tbl[10] = '{8'h01, 16'h0, 0, 16'h0, 16'h0, 0, 0};
    tbl[11] = '{8'h0A, 16'h0, 0, 16'h0, 16'h0, 0, 1};
    tbl[12] = '{8'h0A, 16'h0, 0, 16'h0, 16'h0, 0, 2};
    tbl[13] = '{8'h0A, 16'h0, 0, 16'h0, 16'h0, 0, 3};
    tbl[14] = '{8'h45, 16'h0000, 1, 16'h3078, 16'h4500, 1, 3};
    tbl[15] = '{8'h46, 16'hFF00, 1, 16'h3078, 16'hFF46, 2, 3};
    tbl[16] = '{8'h47, 16'h1111, 1, 16'h3079, 16'h4711, 3, 3};
    tbl[17] = '{8'h7E, 16'h2222, 1, 16'h3079, 16'h227E, 4, 3};
    tbl[18] = '{8'h20, 16'h3333, 1, 16'h307A, 16'h2033, 5, 3};
    tbl[19] = '{8'h0A, 16'h0, 0, 16'h0, 16'h0, 0, 4};
    tbl[20] = '{8'h08, 16'h0, 0, 16'h0, 16'h0, 79, 3};
    tbl[21] = '{8'h0D, 16'h0, 0, 16'h0, 16'h0, 0, 3};

    reset = 1'b0;
    char_in = 8'h0;
    char_valid = 1'b0;
    mem_rdata = 16'h0;
    repeat (3) @(negedge clk);
    chk("rst we", mem_we, 0);
    chk("rst ready", char_ready, 0);
    chk("rst busy", busy, 1);
    chk("rst addr", mem_addr, 16'h3000);
    chk("rst wdata", mem_wdata, 16'h0000);
    chk("rst col", cursor_col, 0);
    chk("rst row", cursor_row, 0);
    reset = 1'b1;
    run_clear("clear0", 0);
    chk("idle busy", busy, 0);
    @(negedge clk);

    foreach (tbl[i]) send(tbl[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 56; i++) begin
      v = '{8'h0A, 16'h0, 0, 16'h0, 16'h0, 0, 4 + i};
      send(v, $sformatf("lf%0d", i));
    end
    v = '{8'h0A, 16'h0, 0, 16'h0, 16'h0, 0, 0};
    send(v, "lf_wrap");
    for (int i = 0; i < 59; i++) begin
      v = '{8'h0A, 16'h0, 0, 16'h0, 16'h0, 0, 1 + i};
      send(v, $sformatf("lfb%0d", i));
    end
    for (int i = 0; i < 79; i++) begin
      v.ch = 8'h30;
      v.rd = 16'h0000;
      v.we = 1;
      v.addr = 16'(16'h3938 + (i >> 1));
      v.wd = (i % 2 == 1) ? 16'h0030 : 16'h3000;
      v.col = i + 1;
      v.row = 59;
      send(v, $sformatf("g59_%0d", i));
    end
    v = '{8'h5A, 16'hBEEF, 1, 16'h395F, 16'hBE5A, 0, 0};
    send(v, "last_cell_wrap");

    v = '{8'h0A, 16'h0, 0, 16'h0, 16'h0, 0, 1};
    send(v, "pre_ff");
    char_in = 8'h0C;
    char_valid = 1'b1;
    @(posedge clk);
    #1;
    char_valid = 1'b0;
    chk("ff ready", char_ready, 0);
    chk("ff busy", busy, 1);
    chk("ff no_we", mem_we, 0);
    run_clear("ff_clear", 100);
    chk("ff w100 addr", mem_addr, 16'h3063);
    reset = 1'b0;
    #1;
    chk("abort no_we", mem_we, 0);
    @(posedge clk);
    #1;
    chk("abort we2", mem_we, 0);
    chk("abort busy", busy, 1);
    chk("abort ready", char_ready, 0);
    chk("abort addr", mem_addr, 16'h3000);
    chk("abort col", cursor_col, 0);
    chk("abort row", cursor_row, 0);
    @(negedge clk);
    reset = 1'b1;
    run_clear("clear1", 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
